// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: the carry chain is split into STAGES segments, one resolved per
// clock, with valid/ready handshakes on both sides and C/V/Z flags on every result.
module pipelined_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Y,
  output logic             C,
  output logic             V,
  output logic             Z,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned SEG  = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] cy_q, cy_d;
  logic [WIDTH-1:0]  a_q  [STAGES];
  logic [WIDTH-1:0]  a_d  [STAGES];
  logic [WIDTH-1:0]  bx_q [STAGES];
  logic [WIDTH-1:0]  bx_d [STAGES];
  logic [WIDTH-1:0]  s_q  [STAGES];
  logic [WIDTH-1:0]  s_d  [STAGES];
  logic              v_q, v_d;
  logic              z_q, z_d;

  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] src_cy;
  logic [WIDTH-1:0]  src_a  [STAGES];
  logic [WIDTH-1:0]  src_bx [STAGES];
  logic [WIDTH-1:0]  src_s  [STAGES];
  logic [SEG:0]      seg_sum;
  logic              advance_c;

  assign advance_c = !vld_q[LAST] || out_ready;
  assign in_ready  = advance_c;

  // Stage k resolves segment k from what stage k-1 registered; bubbles are zeroed so the
  // output registers read 0 whenever out_valid is low.
  always_comb begin
    src_v[0]  = in_valid;
    src_a[0]  = A;
    src_bx[0] = SUB ? ~B : B;
    src_s[0]  = '0;
    src_cy[0] = SUB;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k]  = vld_q[k-1];
      src_a[k]  = a_q[k-1];
      src_bx[k] = bx_q[k-1];
      src_s[k]  = s_q[k-1];
      src_cy[k] = cy_q[k-1];
    end

    seg_sum = '0;
    for (int k = 0; k < STAGES; k++) begin
      seg_sum = {1'b0, src_a[k][k*SEG +: SEG]} + {1'b0, src_bx[k][k*SEG +: SEG]}
              + (SEG+1)'(src_cy[k]);
      vld_d[k] = src_v[k];
      a_d[k]   = '0;
      bx_d[k]  = '0;
      s_d[k]   = '0;
      cy_d[k]  = 1'b0;
      if (src_v[k]) begin
        a_d[k]                = src_a[k];
        bx_d[k]               = src_bx[k];
        s_d[k]                = src_s[k];
        s_d[k][k*SEG +: SEG]  = seg_sum[SEG-1:0];
        cy_d[k]               = seg_sum[SEG];
      end
    end

    v_d = (a_d[LAST][WIDTH-1] == bx_d[LAST][WIDTH-1]) &&
          (s_d[LAST][WIDTH-1] != a_d[LAST][WIDTH-1]);
    z_d = vld_d[LAST] && (s_d[LAST] == '0);
  end

  // Whole pipeline shifts together or holds together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      cy_q  <= '0;
      a_q   <= '{default: '0};
      bx_q  <= '{default: '0};
      s_q   <= '{default: '0};
      v_q   <= 1'b0;
      z_q   <= 1'b0;
    end else if (advance_c) begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      a_q   <= a_d;
      bx_q  <= bx_d;
      s_q   <= s_d;
      v_q   <= v_d;
      z_q   <= z_d;
    end
  end

  assign Y         = s_q[LAST];
  assign C         = cy_q[LAST];
  assign V         = v_q;
  assign Z         = z_q;
  assign out_valid = vld_q[LAST];

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: a 32-bit/4-stage and an 8-bit/1-stage instance, each with a
// queue scoreboard fed at acceptance and drained at output transfers.
module tb_pipelined_adder;

  typedef struct packed {
    logic        c;
    logic        v;
    logic        z;
    logic [63:0] y;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sub, iv, ordy, irdy, c, v, z, ov;
  logic [31:0] a, b, y;
  logic        rst8, sub8, iv8, ordy8, irdy8, c8, v8, z8, ov8;
  logic [7:0]  a8, b8, y8;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q32[$];
  exp_t q8[$];
  exp_t e32, g32, e8, g8;

  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .A(a), .B(b), .SUB(sub), .in_valid(iv), .in_ready(irdy),
    .Y(y), .C(c), .V(v), .Z(z), .out_valid(ov), .out_ready(ordy)
  );

  pipelined_adder #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst(rst8), .A(a8), .B(b8), .SUB(sub8), .in_valid(iv8), .in_ready(irdy8),
    .Y(y8), .C(c8), .V(v8), .Z(z8), .out_valid(ov8), .out_ready(ordy8)
  );

  // Reference built from exact signed/unsigned arithmetic rather than a carry chain.
  function automatic exp_t model(input logic [63:0] aa, input logic [63:0] bb,
                                 input logic s, input int w);
    exp_t        m;
    logic [63:0] mask, raw;
    longint      sa, sb, r, lim;
    mask = (64'd1 << w) - 64'd1;
    sa = $signed(aa);
    sb = $signed(bb);
    if (aa[w-1]) sa = sa - (longint'(1) << w);
    if (bb[w-1]) sb = sb - (longint'(1) << w);
    r   = s ? sa - sb : sa + sb;
    lim = longint'(1) << (w - 1);
    raw = s ? aa - bb : aa + bb;
    m.y = raw & mask;
    m.v = (r >= lim) || (r < -lim);
    m.c = s ? (aa >= bb) : raw[w];
    m.z = (m.y == 64'd0);
    return m;
  endfunction

  always @(negedge clk) begin
    if (rst) q32.delete();
    else begin
      if (ov && ordy) begin
        n_cmp++;
        if (q32.size() == 0) begin
          n_bad++;
          $display("FAIL sb32_extra: unexpected result Y=%h", y);
        end else begin
          e32 = q32.pop_front();
          g32 = {c, v, z, 64'(y)};
          if (g32 !== e32) begin
            n_bad++;
            $display("FAIL sb32_result: got Y=%h CVZ=%b%b%b, want Y=%h CVZ=%b%b%b",
                     g32.y, g32.c, g32.v, g32.z, e32.y, e32.c, e32.v, e32.z);
          end
        end
      end
      if (iv && irdy) q32.push_back(model(64'(a), 64'(b), sub, 32));
    end
  end

  always @(negedge clk) begin
    if (rst8) q8.delete();
    else begin
      if (ov8 && ordy8) begin
        n_cmp++;
        if (q8.size() == 0) begin
          n_bad++;
          $display("FAIL sb8_extra: unexpected result Y=%h", y8);
        end else begin
          e8 = q8.pop_front();
          g8 = {c8, v8, z8, 64'(y8)};
          if (g8 !== e8) begin
            n_bad++;
            $display("FAIL sb8_result: got Y=%h CVZ=%b%b%b, want Y=%h CVZ=%b%b%b",
                     g8.y, g8.c, g8.v, g8.z, e8.y, e8.c, e8.v, e8.z);
          end
        end
      end
      if (iv8 && irdy8) q8.push_back(model(64'(a8), 64'(b8), sub8, 8));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    iv = 1'b1; a = $urandom; b = $urandom; sub = 1'($urandom);
    iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({ov, c, v, z, y} !== 36'd0 || {ov8, c8, v8, z8, y8} !== 12'd0) begin
        n_bad++;
        $display("FAIL reset_outputs: got ov=%b Y=%h ov8=%b Y8=%h, want all 0", ov, y, ov8, y8);
      end
      tick();
    end
    rst = 1'b0; rst8 = 1'b0; iv = 1'b0; iv8 = 1'b0;
    #1;
    n_cmp++;
    if (irdy !== 1'b1 || irdy8 !== 1'b1 || ov !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: got in_ready=%b/%b ov=%b, want 1/1 0", irdy, irdy8, ov);
    end
  endtask

  task automatic test_carry_ripple();
    tick();
    a = 32'hFFFF_FFFF; b = 32'h0000_0001; sub = 1'b0; iv = 1'b1; ordy = 1'b1;
    tick();
    iv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (ov !== (i == 3)) begin
        n_bad++;
        $display("FAIL ripple_latency[%0d]: got out_valid=%b, want %b", i, ov, i == 3);
      end
      if (i == 3) begin
        n_cmp++;
        if ({y, c, v, z} !== {32'h0, 1'b1, 1'b0, 1'b1}) begin
          n_bad++;
          $display("FAIL ripple_value: got Y=%h CVZ=%b%b%b, want 00000000 101", y, c, v, z);
        end
      end
      tick();
    end
  endtask

  task automatic test_sub_overflow();
    logic [31:0] ta [3];
    logic [31:0] tb [3];
    logic [31:0] ey [3];
    logic        ts [3];
    logic        ec [3];
    logic        ev [3];
    int          w;
    ta = '{32'd5, 32'h7FFF_FFFF, 32'h8000_0000};
    tb = '{32'd7, 32'h0000_0001, 32'h0000_0001};
    ts = '{1'b1, 1'b0, 1'b1};
    ey = '{32'hFFFF_FFFE, 32'h8000_0000, 32'h7FFF_FFFF};
    ec = '{1'b0, 1'b0, 1'b1};
    ev = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      tick();
      a = ta[i]; b = tb[i]; sub = ts[i]; iv = 1'b1;
      tick();
      iv = 1'b0;
      w = 0;
      while (!ov && w < 10) begin
        tick();
        w++;
      end
      n_cmp++;
      if (!ov) begin
        n_bad++;
        $display("FAIL subovf_timeout[%0d]: got no out_valid, want one within 10 cycles", i);
      end else if ({y, c, v, z} !== {ey[i], ec[i], ev[i], 1'b0}) begin
        n_bad++;
        $display("FAIL subovf[%0d]: got Y=%h CVZ=%b%b%b, want Y=%h CVZ=%b%b0",
                 i, y, c, v, z, ey[i], ec[i], ev[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int cnt = 0, first = -1, last = -1;
    tick();
    ordy = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      iv = (cyc < 8);
      a = $urandom; b = $urandom; sub = 1'(cyc & 1);
      #1;
      if (ov) begin
        cnt++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      tick();
    end
    iv = 1'b0;
    n_cmp++;
    if (cnt != 8 || last - first != 7 || q32.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_stream: got %0d valids span %0d left %0d, want 8 span 7 left 0",
               cnt, last - first, q32.size());
    end
  endtask

  task automatic test_backpressure();
    int          sent = 0, rcv = 0, cyc = 0;
    logic        acc;
    logic [35:0] snap = '0;
    tick();
    a = $urandom; b = $urandom; sub = 1'($urandom);
    while (rcv < 6 && cyc < 40) begin
      iv   = (sent < 6);
      ordy = !(cyc >= 4 && cyc < 9);
      #1;
      if (cyc == 4) begin
        snap = {ov, c, v, z, y};
        n_cmp++;
        if (ov !== 1'b1) begin
          n_bad++;
          $display("FAIL bp_start: got out_valid=%b, want 1", ov);
        end
      end
      if (cyc >= 4 && cyc < 9) begin
        n_cmp++;
        if (irdy !== 1'b0) begin
          n_bad++;
          $display("FAIL bp_in_ready[%0d]: got %b, want 0", cyc, irdy);
        end
      end
      if (cyc >= 5 && cyc < 9) begin
        n_cmp++;
        if ({ov, c, v, z, y} !== snap) begin
          n_bad++;
          $display("FAIL bp_hold[%0d]: got %h, want %h", cyc, {ov, c, v, z, y}, snap);
        end
      end
      acc = iv && irdy;
      if (ov && ordy) rcv++;
      tick();
      if (acc) begin
        sent++;
        a = $urandom; b = $urandom; sub = 1'($urandom);
      end
      cyc++;
    end
    iv = 1'b0; ordy = 1'b1;
    n_cmp++;
    if (rcv != 6 || q32.size() != 0) begin
      n_bad++;
      $display("FAIL bp_drain: got %0d results, %0d pending, want 6 and 0", rcv, q32.size());
    end
  endtask

  task automatic test_reset_midflight();
    logic seen = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom; sub = 1'(i & 1); iv = 1'b1;
      tick();
    end
    iv = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (ov !== 1'b0 || y !== 32'd0) begin
      n_bad++;
      $display("FAIL midrst_assert: got ov=%b Y=%h, want 0 0", ov, y);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (ov) seen = 1'b1;
      tick();
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_flush: got out_valid after reset, want none");
    end
  endtask

  task automatic test_stages1();
    int   cnt = 0;
    logic seen = 1'b0;
    tick();
    a8 = 8'h7F; b8 = 8'h01; sub8 = 1'b0; iv8 = 1'b1; ordy8 = 1'b1;
    tick();
    iv8 = 1'b0;
    n_cmp++;
    if ({ov8, y8, c8, v8, z8} !== {1'b1, 8'h80, 1'b0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL s1_latency: got ov=%b Y=%h CVZ=%b%b%b, want 1 80 010", ov8, y8, c8, v8, z8);
    end
    tick();
    n_cmp++;
    if (ov8 !== 1'b0 || y8 !== 8'h00) begin
      n_bad++;
      $display("FAIL s1_bubble: got ov=%b Y=%h, want 0 00", ov8, y8);
    end
    for (int cyc = 0; cyc < 8; cyc++) begin
      iv8 = (cyc < 6);
      a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'(cyc & 1);
      #1;
      if (ov8) cnt++;
      tick();
    end
    iv8 = 1'b0;
    n_cmp++;
    if (cnt != 6 || q8.size() != 0) begin
      n_bad++;
      $display("FAIL s1_stream: got %0d valids %0d pending, want 6 and 0", cnt, q8.size());
    end
    ordy8 = 1'b0; a8 = 8'h12; b8 = 8'h34; sub8 = 1'b1; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    rst8 = 1'b1;
    #1;
    n_cmp++;
    if (ov8 !== 1'b0 || y8 !== 8'h00) begin
      n_bad++;
      $display("FAIL s1_midrst: got ov=%b Y=%h, want 0 00", ov8, y8);
    end
    tick();
    rst8 = 1'b0; ordy8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (ov8) seen = 1'b1;
      tick();
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL s1_flush: got out_valid after reset, want none");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rst8 = 1'b1;
    iv = 1'b0; a = '0; b = '0; sub = 1'b0; ordy = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; ordy8 = 1'b1;
    test_reset();
    test_carry_ripple();
    test_sub_overflow();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_stages1();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined add/subtract unit that succeeds the single-cycle combinational 32-bit adder in the datapath catalog.
- The carry chain is split into STAGES equal segments, and one segment is resolved per clock.
- Operands enter and results leave through valid/ready handshakes, with back-pressure.
- Each result carries carry (C), signed overflow (V) and zero (Z) flags for the ALU/branch path.

Parameters:
- WIDTH, 32, operand/result width in bits; must be divisible by STAGES.
- STAGES, 4, pipeline depth and carry segment count; 1 <= STAGES <= WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- SUB  input  1  0: Y = A + B; 1: Y = A - B
- in_valid  input  1  A/B/SUB valid this cycle
- in_ready  output  1  block accepts operands this cycle
- Y  output  WIDTH  result
- C  output  1  carry out of MSB (for SUB: 1 = no borrow)
- V  output  1  two's-complement signed overflow
- Z  output  1  Y == 0
- out_valid  output  1  Y/C/V/Z valid
- out_ready  input  1  consumer accepts result this cycle

Behaviour:
- Reset: rst=1 asynchronously clears every stage valid bit and every data/flag register. Outputs during and after reset: out_valid=0, Y=0, C=0, V=0, Z=0. in_ready is 1 once rst deasserts.
- Arithmetic:
  - Effective operand Bx = SUB ? ~B : B; carry-in = SUB.
  - Full result = A + Bx + SUB, modulo 2^WIDTH.
  - C = carry out of bit WIDTH-1.
  - V = (A[MSB] == Bx[MSB]) && (Y[MSB] != A[MSB]).
  - Z = (Y == 0).
  - Results must be bit-identical to a combinational reference for all inputs.
- Segmentation:
  - SEG = WIDTH/STAGES.
  - Stage k (k = 0..STAGES-1) adds bits [k*SEG +: SEG] using the carry registered by stage k-1; stage 0 uses SUB as carry-in.
  - Operand bits for later segments and the SUB/MSB information needed for V are carried forward in the pipeline registers.
  - Completed low segments are carried forward.
  - Flags are computed in the final stage from registered values.
- Latency: an operand accepted at edge n (in_valid && in_ready) produces out_valid=1 with its result after edge n+STAGES-1 when there is no stall. STAGES=1 therefore gives a one-register result. Throughput is one operation per cycle.
- Handshake:
  - advance = !out_valid || out_ready.
  - in_ready = advance, combinational.
  - When advance=1, all stages shift by one on the edge: stage 0 loads (in_valid, operands) and the last stage loads from stage STAGES-2. A bubble (valid=0) shifts like data.
  - When advance=0, all registers hold, and Y/C/V/Z/out_valid remain stable.
  - in_valid while in_ready=0 is ignored; the producer must hold its operands.
  - A transfer out occurs when out_valid && out_ready.
- Ordering: results emerge strictly in acceptance order, with no drops and no duplicates.
- Data registers of invalid stages are don't-care internally, but Y/C/V/Z must read 0 whenever out_valid=0 after reset. Gate or clear them on a bubble.
- Simultaneous events:
  - Output transfer and input acceptance in the same cycle are legal and are the normal streaming case.
  - rst overrides everything.
- Reset mid-operation: all in-flight operations are discarded, and none appear after rst deasserts.
- SUB is sampled per operation and may change every accepted cycle.

Test Plan (WIDTH=32, STAGES=4 unless noted):
- Reset: assert rst with random inputs, in_valid=1 -> out_valid=0, Y=0, C=V=Z=0 immediately and for as long as rst is held; in_ready=1 after release.
- Carry ripple across all segments: A=0xFFFFFFFF, B=0x00000001, SUB=0, out_ready=1 -> 3 edges after acceptance (4th cycle) Y=0x00000000, C=1, Z=1, V=0, out_valid=1 for exactly one cycle.
- Subtract/overflow:
  - 5 - 7 -> Y=0xFFFFFFFE, C=0, V=0, Z=0.
  - 0x7FFFFFFF + 0x00000001 -> Y=0x80000000, V=1, C=0.
  - 0x80000000 - 0x00000001 -> Y=0x7FFFFFFF, V=1, C=1.
- Streaming: 8 back-to-back random ops with alternating SUB, out_ready=1 -> 8 consecutive out_valid cycles, results in order and matching the model.
- Back-pressure: stream 6 ops, drop out_ready for 5 cycles while the result is valid -> in_ready=0 and Y/flags stable throughout; after release all 6 results arrive in order with none lost.
- Reset mid-flight: accept 3 ops, pulse rst for 1 cycle before any result -> no out_valid afterwards. Repeat with STAGES=1 and WIDTH=8 (e.g. 0x7F+0x01 -> 0x80, V=1) to confirm latency 1 and correct parametrisation.
